// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing generator: register address map,
// default timing values and the colour field layout of the pixel word.
package vga_pkg;

    localparam int ADDR_H_LEFT     = 0;
    localparam int ADDR_V_LEFT     = 1;
    localparam int ADDR_H_RIGHT    = 2;
    localparam int ADDR_V_RIGHT    = 3;
    localparam int ADDR_H_SYNC     = 4;
    localparam int ADDR_V_SYNC     = 5;
    localparam int ADDR_H_MAX      = 6;
    localparam int ADDR_V_MAX      = 7;
    localparam int ADDR_PATTERN    = 8;
    localparam int NUM_TIMING_REGS = 8;

    localparam int DEF_CONFIG_WIDTH = 12;
    localparam int DEF_DATA_WIDTH   = 12;
    localparam int DEF_COLOR_WIDTH  = 4;

    localparam int DEF_H_LEFT  = 1;
    localparam int DEF_V_LEFT  = 2;
    localparam int DEF_H_RIGHT = 7;
    localparam int DEF_V_RIGHT = 8;
    localparam int DEF_H_SYNC  = 1;
    localparam int DEF_V_SYNC  = 0;
    localparam int DEF_H_MAX   = 10;
    localparam int DEF_V_MAX   = 12;

    // Pixel word is {R,G,B}; the enum value is the field's position from the LSB.
    typedef enum int {
        FIELD_BLUE  = 0,
        FIELD_GREEN = 1,
        FIELD_RED   = 2
    } color_field_e;

    function automatic int field_lsb(input color_field_e field, input int color_width);
        return int'(field) * color_width;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// H/V counters, shadowed timing registers and sync/visible decode.
// With VGA_TEST_PATTERN_EN defined it also exports the colour-bar index.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CONFIG_WIDTH      = DEF_CONFIG_WIDTH,
    parameter int H_LEFT_MARGIN_RD  = DEF_H_LEFT,
    parameter int V_LEFT_MARGIN_RD  = DEF_V_LEFT,
    parameter int H_RIGHT_MARGIN_RD = DEF_H_RIGHT,
    parameter int V_RIGHT_MARGIN_RD = DEF_V_RIGHT,
    parameter int H_SYNC_PULSE_RD   = DEF_H_SYNC,
    parameter int V_SYNC_PULSE_RD   = DEF_V_SYNC,
    parameter int H_COUNT_MAX_RD    = DEF_H_MAX,
    parameter int V_COUNT_MAX_RD    = DEF_V_MAX
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [CONFIG_WIDTH-1:0] wr_addr,
    input  logic [CONFIG_WIDTH-1:0] wr_data,
    output logic                    hs_act,
    output logic                    vs_act,
    output logic                    vis
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [2:0]              bar_idx
`endif
);

    logic [CONFIG_WIDTH-1:0]    shadow_reg [NUM_TIMING_REGS];
    logic [CONFIG_WIDTH-1:0]    active_reg [NUM_TIMING_REGS];
    logic [NUM_TIMING_REGS-1:0] wr_hit;
    logic [CONFIG_WIDTH-1:0]    h_cnt_reg, h_cnt_next;
    logic [CONFIG_WIDTH-1:0]    v_cnt_reg, v_cnt_next;
    logic                       h_wrap, v_wrap, frame_wrap;

    function automatic logic [CONFIG_WIDTH-1:0] reset_value(input int idx);
        case (idx)
            ADDR_H_LEFT:  return CONFIG_WIDTH'(H_LEFT_MARGIN_RD);
            ADDR_V_LEFT:  return CONFIG_WIDTH'(V_LEFT_MARGIN_RD);
            ADDR_H_RIGHT: return CONFIG_WIDTH'(H_RIGHT_MARGIN_RD);
            ADDR_V_RIGHT: return CONFIG_WIDTH'(V_RIGHT_MARGIN_RD);
            ADDR_H_SYNC:  return CONFIG_WIDTH'(H_SYNC_PULSE_RD);
            ADDR_V_SYNC:  return CONFIG_WIDTH'(V_SYNC_PULSE_RD);
            ADDR_H_MAX:   return CONFIG_WIDTH'(H_COUNT_MAX_RD);
            default:      return CONFIG_WIDTH'(V_COUNT_MAX_RD);
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TIMING_REGS; gi++) begin : g_wr_hit
            assign wr_hit[gi] = wr_en && (wr_addr == CONFIG_WIDTH'(gi));
        end
    endgenerate

    // Shadow takes writes at any time; active only reloads at the frame wrap,
    // so a write landing on the wrap cycle waits for the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TIMING_REGS; i++) begin
                shadow_reg[i] <= reset_value(i);
                active_reg[i] <= reset_value(i);
            end
        end else begin
            for (int i = 0; i < NUM_TIMING_REGS; i++) begin
                if (wr_hit[i]) shadow_reg[i] <= wr_data;
                if (frame_wrap) active_reg[i] <= shadow_reg[i];
            end
        end
    end

    // ">=" lets a counter left beyond a shortened maximum wrap on the next cycle.
    always_comb begin
        h_wrap     = h_cnt_reg >= active_reg[ADDR_H_MAX];
        v_wrap     = v_cnt_reg >= active_reg[ADDR_V_MAX];
        frame_wrap = h_wrap && v_wrap;
        h_cnt_next = h_wrap ? '0 : h_cnt_reg + CONFIG_WIDTH'(1);
        v_cnt_next = v_cnt_reg;
        if (h_wrap) begin
            v_cnt_next = v_wrap ? '0 : v_cnt_reg + CONFIG_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
        end
    end

    assign hs_act = h_cnt_reg < active_reg[ADDR_H_SYNC];
    assign vs_act = v_cnt_reg < active_reg[ADDR_V_SYNC];
    assign vis    = (h_cnt_reg >= active_reg[ADDR_H_LEFT]) && (h_cnt_reg < active_reg[ADDR_H_RIGHT])
                 && (v_cnt_reg >= active_reg[ADDR_V_LEFT]) && (v_cnt_reg < active_reg[ADDR_V_RIGHT]);

`ifdef VGA_TEST_PATTERN_EN
    // Only the low three bits of (h_cnt - H_LEFT) pick the bar.
    assign bar_idx = h_cnt_reg[2:0] - active_reg[ADDR_H_LEFT][2:0];
`endif

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing controller top: config write port and registered sync/RGB outputs.
// Optional colour-bar test pattern at address 8 when VGA_TEST_PATTERN_EN is defined.
module vga_ctrl
    import vga_pkg::*;
#(
    parameter int CONFIG_WIDTH      = DEF_CONFIG_WIDTH,
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int COLOR_WIDTH       = DEF_COLOR_WIDTH,
    parameter int H_LEFT_MARGIN_RD  = DEF_H_LEFT,
    parameter int V_LEFT_MARGIN_RD  = DEF_V_LEFT,
    parameter int H_RIGHT_MARGIN_RD = DEF_H_RIGHT,
    parameter int V_RIGHT_MARGIN_RD = DEF_V_RIGHT,
    parameter int H_SYNC_PULSE_RD   = DEF_H_SYNC,
    parameter int V_SYNC_PULSE_RD   = DEF_V_SYNC,
    parameter int H_COUNT_MAX_RD    = DEF_H_MAX,
    parameter int V_COUNT_MAX_RD    = DEF_V_MAX
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    c_valid,
    input  logic [CONFIG_WIDTH-1:0] c_addr,
    input  logic [CONFIG_WIDTH-1:0] c_data,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    c_ready,
    output logic                    HSync,
    output logic                    VSync,
    output logic [COLOR_WIDTH-1:0]  RED,
    output logic [COLOR_WIDTH-1:0]  GREEN,
    output logic [COLOR_WIDTH-1:0]  BLUE
);

    localparam int RED_LSB   = field_lsb(FIELD_RED, COLOR_WIDTH);
    localparam int GREEN_LSB = field_lsb(FIELD_GREEN, COLOR_WIDTH);
    localparam int BLUE_LSB  = field_lsb(FIELD_BLUE, COLOR_WIDTH);

    logic                  c_ready_reg;
    logic                  hsync_reg, vsync_reg;
    logic [DATA_WIDTH-1:0] rgb_reg;
    logic [DATA_WIDTH-1:0] pixel;
    logic                  wr_en;
    logic                  hs_act, vs_act, vis;

    assign wr_en = c_valid && c_ready_reg;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_idx;
    logic       pattern_reg;

    // Pattern enable is deliberately unshadowed: it switches on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_reg <= 1'b0;
        end else if (wr_en && (c_addr == CONFIG_WIDTH'(ADDR_PATTERN))) begin
            pattern_reg <= c_data[0];
        end
    end

    assign pixel = pattern_reg ? {{COLOR_WIDTH{bar_idx[2]}},
                                  {COLOR_WIDTH{bar_idx[1]}},
                                  {COLOR_WIDTH{bar_idx[0]}}}
                               : data_in;
`else
    assign pixel = data_in;
`endif

    vga_timing_gen #(
        .CONFIG_WIDTH      (CONFIG_WIDTH),
        .H_LEFT_MARGIN_RD  (H_LEFT_MARGIN_RD),
        .V_LEFT_MARGIN_RD  (V_LEFT_MARGIN_RD),
        .H_RIGHT_MARGIN_RD (H_RIGHT_MARGIN_RD),
        .V_RIGHT_MARGIN_RD (V_RIGHT_MARGIN_RD),
        .H_SYNC_PULSE_RD   (H_SYNC_PULSE_RD),
        .V_SYNC_PULSE_RD   (V_SYNC_PULSE_RD),
        .H_COUNT_MAX_RD    (H_COUNT_MAX_RD),
        .V_COUNT_MAX_RD    (V_COUNT_MAX_RD)
    ) u_timing (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (c_addr),
        .wr_data (c_data),
        .hs_act  (hs_act),
        .vs_act  (vs_act),
        .vis     (vis)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .bar_idx (bar_idx)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            c_ready_reg <= 1'b0;
            hsync_reg   <= 1'b1;
            vsync_reg   <= 1'b1;
            rgb_reg     <= '0;
        end else begin
            c_ready_reg <= 1'b1;
            hsync_reg   <= ~hs_act;
            vsync_reg   <= ~vs_act;
            rgb_reg     <= vis ? pixel : '0;
        end
    end

    assign c_ready = c_ready_reg;
    assign HSync   = hsync_reg;
    assign VSync   = vsync_reg;
    assign RED     = rgb_reg[RED_LSB   +: COLOR_WIDTH];
    assign GREEN   = rgb_reg[GREEN_LSB +: COLOR_WIDTH];
    assign BLUE    = rgb_reg[BLUE_LSB  +: COLOR_WIDTH];

endmodule

// File: tb/tb_vga_ctrl.sv
// Self-checking bench for vga_ctrl: reset table, directed timing scenarios and
// random traffic compared against a frame-time reference model.
module tb_vga_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_valid;
    logic [11:0] c_addr;
    logic [11:0] c_data;
    logic [11:0] data_in;
    logic        c_ready;
    logic        HSync, VSync;
    logic [3:0]  RED, GREEN, BLUE;

    always #5 clk = ~clk;

    vga_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .c_valid (c_valid),
        .c_addr  (c_addr),
        .c_data  (c_data),
        .data_in (data_in),
        .c_ready (c_ready),
        .HSync   (HSync),
        .VSync   (VSync),
        .RED     (RED),
        .GREEN   (GREEN),
        .BLUE    (BLUE)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: position is a single frame-time counter t; h/v follow by division.
    int          t;
    logic [11:0] sh [8];
    logic [11:0] ac [8];
    logic        pat;
    logic        m_hs, m_vs, m_rdy;
    logic [11:0] m_rgb;

    function automatic logic [11:0] def_val(input int i);
        case (i)
            0: return 12'd1;
            1: return 12'd2;
            2: return 12'd7;
            3: return 12'd8;
            4: return 12'd1;
            5: return 12'd0;
            6: return 12'd10;
            default: return 12'd12;
        endcase
    endfunction

    function automatic int hlen();
        return int'(ac[6]) + 1;
    endfunction

    task automatic model_step();
        int  h, v, b;
        bit  visible, wr;
        if (rst) begin
            t = 0;
            for (int i = 0; i < 8; i++) begin
                sh[i] = def_val(i);
                ac[i] = def_val(i);
            end
            pat = 1'b0; m_hs = 1'b1; m_vs = 1'b1; m_rgb = '0; m_rdy = 1'b0;
        end else begin
            h = t % hlen();
            v = t / hlen();
            m_hs = !(h < int'(ac[4]));
            m_vs = !(v < int'(ac[5]));
            visible = h >= int'(ac[0]) && h < int'(ac[2]) && v >= int'(ac[1]) && v < int'(ac[3]);
            b = (h - int'(ac[0])) & 7;
            if (!visible) m_rgb = '0;
            else if (pat) m_rgb = {(b & 4) != 0 ? 4'hF : 4'h0, (b & 2) != 0 ? 4'hF : 4'h0,
                                   (b & 1) != 0 ? 4'hF : 4'h0};
            else m_rgb = data_in;
            wr = c_valid && m_rdy;
            if (t == hlen() * (int'(ac[7]) + 1) - 1) begin
                for (int i = 0; i < 8; i++) ac[i] = sh[i];
                t = 0;
            end else begin
                t++;
            end
            if (wr && c_addr < 12'd8) sh[c_addr[2:0]] = c_data;
`ifdef VGA_TEST_PATTERN_EN
            if (wr && c_addr == 12'd8) pat = c_data[0];
`endif
            m_rdy = 1'b1;
        end
    endtask

    task automatic cyc(input logic r, input logic cv, input logic [11:0] a, input logic [11:0] d,
                       input logic [11:0] din);
        rst = r; c_valid = cv; c_addr = a; c_data = d; data_in = din;
        @(posedge clk);
        model_step();
        #1;
        check("model_hsync", int'(HSync), int'(m_hs));
        check("model_vsync", int'(VSync), int'(m_vs));
        check("model_rgb", int'({RED, GREEN, BLUE}), int'(m_rgb));
        check("model_ready", int'(c_ready), int'(m_rdy));
    endtask

    int cnt_hs, cnt_vs, cnt_vis, cnt_rdy, cnt_other;

    task automatic run_cycles(input int n, input logic cv, input logic [11:0] a, input logic [11:0] d);
        cnt_hs = 0; cnt_vs = 0; cnt_vis = 0; cnt_rdy = 0; cnt_other = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, cv, a, d, 12'hAFA);
            if (!HSync) cnt_hs++;
            if (!VSync) cnt_vs++;
            if ({RED, GREEN, BLUE} != 12'h000) cnt_vis++;
            if ({RED, GREEN, BLUE} != 12'h000 && {RED, GREEN, BLUE} != 12'hAFA) cnt_other++;
            if (c_ready) cnt_rdy++;
        end
    endtask

    // Runs idle cycles until the model has just wrapped the frame; bounded.
    task automatic wait_wrap(output int waited);
        waited = 0;
        cnt_vs = 0;
        do begin
            cyc(1'b0, 1'b0, 12'h0, 12'h0, 12'hAFA);
            if (!VSync) cnt_vs++;
            waited++;
        end while (t != 0 && waited < 1000);
        if (waited >= 1000) check("wrap_timeout", waited, 0);
    endtask

    typedef struct {
        logic        rst;
        logic [11:0] din;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic        rdy;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic r, input logic [11:0] din, input logic hs,
                                input logic vs, input logic [11:0] rgb, input logic rdy);
        vec_t x;
        x.rst = r; x.din = din; x.hs = hs; x.vs = vs; x.rgb = rgb; x.rdy = rdy;
        return x;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited, pos, vpos, exp_wait;

        rst = 1'b1; c_valid = 1'b0; c_addr = '0; c_data = '0; data_in = 12'hAFA;

        // Reset, then the first line (row 0, never visible) plus the start of row 1.
        tbl[0] = mk(1'b1, 12'hAFA, 1'b1, 1'b1, 12'h000, 1'b0);
        tbl[1] = mk(1'b0, 12'h123, 1'b0, 1'b1, 12'h000, 1'b1);
        for (int i = 2; i <= 11; i++) tbl[i] = mk(1'b0, 12'(i * 273), 1'b1, 1'b1, 12'h000, 1'b1);
        tbl[12] = mk(1'b0, 12'hFFF, 1'b0, 1'b1, 12'h000, 1'b1);
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].rst, 1'b0, 12'h0, 12'h0, tbl[i].din);
            check($sformatf("tbl%0d_hsync", i), int'(HSync), int'(tbl[i].hs));
            check($sformatf("tbl%0d_vsync", i), int'(VSync), int'(tbl[i].vs));
            check($sformatf("tbl%0d_rgb", i), int'({RED, GREEN, BLUE}), int'(tbl[i].rgb));
            check($sformatf("tbl%0d_ready", i), int'(c_ready), int'(tbl[i].rdy));
            $display("vec %0d: HSync=%b VSync=%b RGB=%03h c_ready=%b", i, HSync, VSync,
                     {RED, GREEN, BLUE}, c_ready);
        end

        // Default frame: 143 cycles, 13 HSync pulses, no VSync, 6x6 visible pixels.
        run_cycles(143, 1'b0, 12'h0, 12'h0);
        check("s1_hsync_lows", cnt_hs, 13);
        check("s1_vsync_lows", cnt_vs, 0);
        check("s1_visible", cnt_vis, 36);
        check("s1_wrong_colour", cnt_other, 0);
        $display("s1 default frame: hs=%0d vs=%0d vis=%0d", cnt_hs, cnt_vs, cnt_vis);

        // Unmapped address written every cycle: timing unaffected.
        run_cycles(143, 1'b1, 12'hB, 12'h2);
        check("s3_hsync_lows", cnt_hs, 13);
        check("s3_vsync_lows", cnt_vs, 0);
        check("s3_visible", cnt_vis, 36);
        check("s3_ready", cnt_rdy, 143);
        $display("s3 unmapped writes: hs=%0d vs=%0d vis=%0d rdy=%0d", cnt_hs, cnt_vs, cnt_vis, cnt_rdy);

        // V_SYNC=2 mid-frame: nothing until the wrap, then two lines of VSync.
        cyc(1'b0, 1'b1, 12'h5, 12'h2, 12'hAFA);
        wait_wrap(waited);
        check("s2_vsync_before_wrap", cnt_vs, 0);
        run_cycles(143, 1'b0, 12'h0, 12'h0);
        check("s2_vsync_lows", cnt_vs, 22);
        check("s2_hsync_lows", cnt_hs, 13);
        $display("s2 vsync=2: vs=%0d hs=%0d", cnt_vs, cnt_hs);

        // H_LEFT=H_RIGHT: blank picture, syncs keep running.
        cyc(1'b0, 1'b1, 12'h0, 12'h7, 12'hAFA);
        wait_wrap(waited);
        run_cycles(143, 1'b0, 12'h0, 12'h0);
        check("s4_visible", cnt_vis, 0);
        check("s4_hsync_lows", cnt_hs, 13);
        check("s4_vsync_lows", cnt_vs, 22);
        $display("s4 empty window: vis=%0d hs=%0d vs=%0d", cnt_vis, cnt_hs, cnt_vs);
        cyc(1'b0, 1'b1, 12'h0, 12'h1, 12'hAFA);

        // H_MAX=3 written at h_cnt=9: current frame keeps 11-cycle lines.
        waited = 0;
        while ((t % 11) != 9 && waited < 200) begin
            cyc(1'b0, 1'b0, 12'h0, 12'h0, 12'hAFA);
            waited++;
        end
        pos  = t;
        vpos = t / 11;
        cyc(1'b0, 1'b1, 12'h6, 12'h3, 12'hAFA);
        wait_wrap(waited);
        exp_wait = (12 - vpos) * 11 + 1;
        check("s6_old_frame_len", waited, exp_wait);
        cnt_hs = 0; cnt_vis = 0;
        for (int i = 0; i < 52; i++) begin
            cyc(1'b0, 1'b0, 12'h0, 12'h0, 12'hAFA);
            check($sformatf("s6_hsync_%0d", i), int'(HSync), (i % 4) != 0 ? 1 : 0);
            if (!HSync) cnt_hs++;
            if ({RED, GREEN, BLUE} != 12'h000) cnt_vis++;
        end
        check("s6_hsync_lows", cnt_hs, 13);
        check("s6_visible", cnt_vis, 18);
        $display("s6 hmax=3 from pos %0d: old wait=%0d hs=%0d vis=%0d", pos, waited, cnt_hs, cnt_vis);

        // One-cycle reset mid-line: outputs to reset values, then restart from 0,0.
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 12'h0, 12'h0, 12'hAFA);
        cyc(1'b1, 1'b0, 12'h0, 12'h0, 12'hAFA);
        check("s5_rst_hsync", int'(HSync), 1);
        check("s5_rst_vsync", int'(VSync), 1);
        check("s5_rst_rgb", int'({RED, GREEN, BLUE}), 0);
        check("s5_rst_ready", int'(c_ready), 0);
        cyc(1'b0, 1'b0, 12'h0, 12'h0, 12'hAFA);
        check("s5_restart_hsync", int'(HSync), 0);
        check("s5_restart_vsync", int'(VSync), 1);
        check("s5_restart_ready", int'(c_ready), 1);
        $display("s5 reset mid-line: restart HSync=%b VSync=%b c_ready=%b", HSync, VSync, c_ready);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic        r, cv;
            logic [11:0] a, d;
            r  = ($urandom_range(0, 299) == 0);
            cv = ($urandom_range(0, 3) == 0);
            a  = 12'($urandom_range(0, 9));
            d  = 12'($urandom_range(0, 15));
            cyc(r, cv, a, d, 12'($urandom));
        end
        $display("random phase: 4000 cycles done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
